// File: rtl/vertex_attr_mem_if.sv
// Vertex-attribute bus between the primitive loader / fragment interpolator
// (master) and the ping-pong attribute memory (slave).
//   load_*            : fill-side write strobe, address, data, commit, ready
//   vertexSize        : last valid word index per vertex (range checking only)
//   vert_attr_rd_*    : three parallel fixed-latency read lanes, one per vertex
//   prim_valid/_release : read-bank handoff
interface vertex_attr_mem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                             load_wr_en;
    logic [1:0]                       load_wr_vert;
    logic [ADDR_WIDTH-1:0]            load_wr_addr;
    logic [DATA_WIDTH-1:0]            load_wr_data;
    logic                             load_commit;
    logic                             load_ready;
    logic [ADDR_WIDTH-1:0]            vertexSize;
    logic [2:0][0:0]                  vert_attr_rd_en;
    logic [2:0][ADDR_WIDTH-1:0]       vert_attr_rd_addr;
    logic [2:0][DATA_WIDTH-1:0]       vert_attr_rd_data;
    logic                             prim_valid;
    logic                             prim_release;

    modport master (
        output load_wr_en, load_wr_vert, load_wr_addr, load_wr_data, load_commit,
        output vertexSize, vert_attr_rd_en, vert_attr_rd_addr, prim_release,
        input  load_ready, vert_attr_rd_data, prim_valid
    );

    modport slave (
        input  load_wr_en, load_wr_vert, load_wr_addr, load_wr_data, load_commit,
        input  vertexSize, vert_attr_rd_en, vert_attr_rd_addr, prim_release,
        output load_ready, vert_attr_rd_data, prim_valid
    );
endinterface

// File: rtl/vertex_attr_mem.sv
// Double-buffered vertex-attribute memory: the loader fills one bank while the
// interpolator reads the other through three fixed-latency lanes (lane i
// returns vertex i). Banks change hands through commit/release.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   bus         : vertex_attr_mem_if.slave (load, read lanes, bank handoff)
//   err         : sticky protocol error, only when VATTR_MEM_ERR_EN is defined
// Optional feature macro: VATTR_MEM_ERR_EN (error detection, out-of-range and
// invalid-bank reads return 0).
module vertex_attr_mem #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic resetn,
`ifdef VATTR_MEM_ERR_EN
    output logic err,
`endif
    vertex_attr_mem_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned NVERT = 3;
    localparam logic        EMPTY = 1'b0;
    localparam logic        FULL  = 1'b1;

    logic [DATA_WIDTH-1:0]             mem [2][NVERT][DEPTH];
    logic [1:0]                        bank_q, bank_d;
    logic                              wr_sel_q, wr_sel_d;
    logic                              rd_sel_q, rd_sel_d;
    logic                              load_ready_c, prim_valid_c;
    logic                              wr_ok_c, commit_ok_c, release_ok_c;
    logic [NVERT-1:0]                  rd_en_c;
    logic [NVERT-1:0][DATA_WIDTH-1:0]  rd_word_c;
    logic [NVERT-1:0][DATA_WIDTH-1:0]  rd_data_q;

    // Handshake qualifiers, all from pre-edge bank state
    always_comb begin
        load_ready_c = (bank_q[wr_sel_q] == EMPTY);
        prim_valid_c = (bank_q[rd_sel_q] == FULL);
        wr_ok_c      = bus.load_wr_en && load_ready_c && (bus.load_wr_vert != 2'd3);
        commit_ok_c  = bus.load_commit && load_ready_c;
        release_ok_c = bus.prim_release && prim_valid_c;
    end

    assign bus.load_ready        = load_ready_c;
    assign bus.prim_valid        = prim_valid_c;
    assign bus.vert_attr_rd_data = rd_data_q;

    // Bank next state; commit and release can never target the same bank
    always_comb begin
        bank_d   = bank_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (commit_ok_c) begin
            bank_d[wr_sel_q] = FULL;
            wr_sel_d         = ~wr_sel_q;
        end
        if (release_ok_c) begin
            bank_d[rd_sel_q] = EMPTY;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_q   <= {EMPTY, EMPTY};
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Storage is not reset; a write with commit lands in the committed bank
    always_ff @(posedge clk) begin
        if (resetn && wr_ok_c) begin
            mem[wr_sel_q][bus.load_wr_vert][bus.load_wr_addr] <= bus.load_wr_data;
        end
    end

    // Per-lane lookup in the pre-edge read bank
    always_comb begin
        for (int i = 0; i < NVERT; i++) begin
            rd_en_c[i]   = bus.vert_attr_rd_en[i][0];
            rd_word_c[i] = mem[rd_sel_q][i][bus.vert_attr_rd_addr[i]];
`ifdef VATTR_MEM_ERR_EN
            if ((bus.vert_attr_rd_addr[i] > bus.vertexSize) || !prim_valid_c) begin
                rd_word_c[i] = '0;
            end
`endif
        end
    end

    // Output register updates READ_LATENCY-1 edges after the sample edge, so
    // data is usable in the READ_LATENCY-th cycle; lanes without a read hold.
    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    rd_data_q <= '0;
                end else begin
                    for (int i = 0; i < NVERT; i++) begin
                        if (rd_en_c[i]) begin
                            rd_data_q[i] <= rd_word_c[i];
                        end
                    end
                end
            end
        end else begin : g_latn
            localparam int unsigned STAGES = READ_LATENCY - 1;
            logic [NVERT-1:0]                  vld_q [STAGES];
            logic [NVERT-1:0][DATA_WIDTH-1:0]  dat_q [STAGES];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int s = 0; s < STAGES; s++) begin
                        vld_q[s] <= '0;
                        dat_q[s] <= '0;
                    end
                    rd_data_q <= '0;
                end else begin
                    vld_q[0] <= rd_en_c;
                    dat_q[0] <= rd_word_c;
                    for (int s = 1; s < STAGES; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        dat_q[s] <= dat_q[s-1];
                    end
                    for (int i = 0; i < NVERT; i++) begin
                        if (vld_q[STAGES-1][i]) begin
                            rd_data_q[i] <= dat_q[STAGES-1][i];
                        end
                    end
                end
            end
        end
    endgenerate

`ifdef VATTR_MEM_ERR_EN
    logic err_event_c;

    // Any dropped/ignored request or checked-bad read
    always_comb begin
        err_event_c = 1'b0;
        if (bus.load_wr_en && !wr_ok_c) err_event_c = 1'b1;
        if (bus.load_commit && !load_ready_c) err_event_c = 1'b1;
        if (bus.prim_release && !prim_valid_c) err_event_c = 1'b1;
        for (int i = 0; i < NVERT; i++) begin
            if (rd_en_c[i] && ((bus.vert_attr_rd_addr[i] > bus.vertexSize) || !prim_valid_c)) begin
                err_event_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (err_event_c) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_vsize_c;
    assign unused_vsize_c = ^bus.vertexSize;
`endif
endmodule
